// File: rtl/mr_pkg.sv
// Shared configuration for the writeback / register-file slice: widths and the x0 index.
package mr_pkg;

  localparam int XLEN        = 32;
  localparam int REGSEL_BITS = 5;
  localparam int CNT_BITS    = 64;

  localparam logic [REGSEL_BITS-1:0] REG_ZERO = '0;

endpackage : mr_pkg

// File: rtl/mr_scoreboard.sv
// Per-register pending-write scoreboard: reserve/commit priority, idle reduction and
// busy lookups for the two read ports. Entry for x0 is held at zero.
module mr_scoreboard #(
  parameter int REGSEL_BITS = mr_pkg::REGSEL_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_set_valid,
  input  logic [REGSEL_BITS-1:0] i_set_reg,
  input  logic                   i_clr_valid,
  input  logic [REGSEL_BITS-1:0] i_clr_reg,
  input  logic [REGSEL_BITS-1:0] i_rs1_sel,
  input  logic [REGSEL_BITS-1:0] i_rs2_sel,
  output logic                   o_rs1_busy,
  output logic                   o_rs2_busy,
  output logic                   o_idle
);
  import mr_pkg::*;

  localparam int NUM_REGS = 1 << REGSEL_BITS;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Set is applied after clear so a same-cycle reserve wins over the commit.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_valid) w_busy_nxt[i_clr_reg] = 1'b0;
    if (i_set_valid) w_busy_nxt[i_set_reg] = 1'b1;
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= w_busy_nxt;
  end

  assign o_rs1_busy = r_busy[i_rs1_sel];
  assign o_rs2_busy = r_busy[i_rs2_sel];
  assign o_idle     = ~|r_busy;

endmodule : mr_scoreboard

// File: rtl/mr_regfile_wb.sv
// Writeback stage + integer register file with RAW scoreboard and retired-write counter.
// Optional same-cycle commit bypass on the read ports: define MR_WB_BYPASS_EN.
module mr_regfile_wb #(
  parameter int XLEN        = mr_pkg::XLEN,
  parameter int REGSEL_BITS = mr_pkg::REGSEL_BITS,
  parameter int CNT_BITS    = mr_pkg::CNT_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_write_i,
  input  logic [XLEN-1:0]        wb_payload_i,
  input  logic [REGSEL_BITS-1:0] wb_dst_reg_i,
  input  logic                   rsv_valid_i,
  input  logic [REGSEL_BITS-1:0] rsv_reg_i,
  input  logic [REGSEL_BITS-1:0] rs1_sel_i,
  input  logic [REGSEL_BITS-1:0] rs2_sel_i,
  output logic [XLEN-1:0]        rs1_data_o,
  output logic [XLEN-1:0]        rs2_data_o,
  output logic                   hazard_o,
  output logic                   idle_o,
  output logic [CNT_BITS-1:0]    retired_o
);
  import mr_pkg::*;

  localparam int NUM_REGS = 1 << REGSEL_BITS;

  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [CNT_BITS-1:0] r_retired;

  logic            w_commit;
  logic            w_rs1_busy;
  logic            w_rs2_busy;
  logic            w_idle;
  logic            w_rs1_haz;
  logic            w_rs2_haz;
  logic [XLEN-1:0] w_rs1_arr;
  logic [XLEN-1:0] w_rs2_arr;

  // x0 commits are dropped from the array but still count as retired.
  assign w_commit = wb_write_i && (wb_dst_reg_i != REG_ZERO);

  mr_scoreboard #(
    .REGSEL_BITS (REGSEL_BITS)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_set_valid (rsv_valid_i),
    .i_set_reg   (rsv_reg_i),
    .i_clr_valid (wb_write_i),
    .i_clr_reg   (wb_dst_reg_i),
    .i_rs1_sel   (rs1_sel_i),
    .i_rs2_sel   (rs2_sel_i),
    .o_rs1_busy  (w_rs1_busy),
    .o_rs2_busy  (w_rs2_busy),
    .o_idle      (w_idle)
  );

  // NOTE: the array is reset because architectural state must read zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[wb_dst_reg_i] <= wb_payload_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_retired <= '0;
    else if (wb_write_i) r_retired <= r_retired + CNT_BITS'(1);
  end

  assign w_rs1_arr = (rs1_sel_i == REG_ZERO) ? '0 : r_regs[rs1_sel_i];
  assign w_rs2_arr = (rs2_sel_i == REG_ZERO) ? '0 : r_regs[rs2_sel_i];

`ifdef MR_WB_BYPASS_EN
  logic w_rs1_byp;
  logic w_rs2_byp;
  logic w_rs1_rsv;
  logic w_rs2_rsv;

  // w_commit already excludes x0, so a match implies a nonzero selector.
  assign w_rs1_byp = w_commit && (wb_dst_reg_i == rs1_sel_i);
  assign w_rs2_byp = w_commit && (wb_dst_reg_i == rs2_sel_i);
  assign w_rs1_rsv = rsv_valid_i && (rsv_reg_i == rs1_sel_i);
  assign w_rs2_rsv = rsv_valid_i && (rsv_reg_i == rs2_sel_i);

  assign rs1_data_o = w_rs1_byp ? wb_payload_i : w_rs1_arr;
  assign rs2_data_o = w_rs2_byp ? wb_payload_i : w_rs2_arr;
  // A newer writer dispatched this cycle keeps the stall despite the bypassed data.
  assign w_rs1_haz  = w_rs1_busy && (!w_rs1_byp || w_rs1_rsv);
  assign w_rs2_haz  = w_rs2_busy && (!w_rs2_byp || w_rs2_rsv);
`else
  assign rs1_data_o = w_rs1_arr;
  assign rs2_data_o = w_rs2_arr;
  assign w_rs1_haz  = w_rs1_busy;
  assign w_rs2_haz  = w_rs2_busy;
`endif

  assign hazard_o  = w_rs1_haz | w_rs2_haz;
  assign idle_o    = w_idle;
  assign retired_o = r_retired;

endmodule : mr_regfile_wb
